btn_seq_display_ctrl: RTL



---
 rtl/btn_seq_display_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/btn_seq_display_ctrl.sv
// Post-fill unlock sequencer: debounces the pushbuttons, runs the D -> L -> R
// press-sequence FSM with a per-step timeout and scans the 4-digit display.
module btn_seq_display_ctrl #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SCAN_CYC     = 150000,
  parameter int TIMEOUT_CYC  = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnU,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic [2:0] stage,
  output logic       unlocked,
  output logic       err
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int SCW = $clog2(SCAN_CYC + 1);
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYC - 1);
  localparam logic [TOW-1:0] TMO_LAST  = TOW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] G_D     = 8'hA1;
  localparam logic [7:0] G_L     = 8'hC7;
  localparam logic [7:0] G_R     = 8'hAF;
  localparam logic [7:0] G_U     = 8'hC1;
  localparam logic [7:0] G_E     = 8'h86;
  localparam logic [7:0] G_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_D = 3'd1,
    S_WAIT_L = 3'd2,
    S_WAIT_R = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  // Per-state pattern, packed digit3..digit0; unused codes show blank.
  function automatic logic [7:0] glyph(input state_t s, input logic [1:0] slot);
    logic [31:0] pat;
    case (s)
      S_WAIT_D: pat = {G_BLANK, G_BLANK, G_BLANK, G_D};
      S_WAIT_L: pat = {G_BLANK, G_BLANK, G_L, G_BLANK};
      S_WAIT_R: pat = {G_BLANK, G_R, G_BLANK, G_BLANK};
      S_DONE:   pat = {G_D, G_L, G_R, G_U};
      S_FAIL:   pat = {G_BLANK, G_E, G_R, G_R};
      default:  pat = {4{G_BLANK}};
    endcase
    return pat[{slot, 3'b000} +: 8];
  endfunction

  state_t         state, state_nxt;
  logic [3:0]     btn_raw, sync_p0, sync_p1, deb_p2, deb_p3, press;
  logic [DBW-1:0] deb_cnt [4];
  logic [TOW-1:0] tmr;
  logic [SCW-1:0] scan_cnt;
  logic [1:0]     scan_idx;
  logic [7:0]     glyph_cur;
  logic [3:0]     exp_mask;
  state_t         adv_state;
  logic           is_wait;

  // Bit order throughout: 0=D, 1=L, 2=R, 3=U.
  assign btn_raw = {btnU, btnR, btnL, btnD};
  assign press   = deb_p2 & ~deb_p3;

  // p0/p1: two-flop synchronizer; p2: debounced level; p3: edge-detect delay
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb_p2  <= '0;
      deb_p3  <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      deb_p3  <= deb_p2;
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          deb_p2[i]  <= sync_p1[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign is_wait = (state == S_WAIT_D) || (state == S_WAIT_L) || (state == S_WAIT_R);

  always_comb begin
    state_nxt = state;
    exp_mask  = 4'b0001;
    adv_state = S_WAIT_L;
    case (state)
      S_WAIT_L: begin exp_mask = 4'b0010; adv_state = S_WAIT_R; end
      S_WAIT_R: begin exp_mask = 4'b0100; adv_state = S_DONE;   end
      default: ;
    endcase

    case (state)
      S_IDLE: if (arm) state_nxt = S_WAIT_D;
      S_WAIT_D, S_WAIT_L, S_WAIT_R: begin
        // Matching the one-hot mask also rules out simultaneous presses.
        if (!arm)                    state_nxt = S_IDLE;
        else if (press == exp_mask)  state_nxt = adv_state;
        else if (press != 4'b0000)   state_nxt = S_FAIL;
        else if (tmr == TMO_LAST)    state_nxt = S_FAIL;
      end
      S_DONE: state_nxt = S_DONE;
      S_FAIL: begin
        if (!arm)          state_nxt = S_IDLE;
        else if (press[3]) state_nxt = S_WAIT_D;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !is_wait) tmr <= '0;
      else                                tmr <= tmr + 1'b1;
    end
  end

  assign stage    = (state > S_FAIL) ? 3'd0 : 3'(state);
  assign unlocked = (state == S_DONE);
  assign err      = (state == S_FAIL);

  assign glyph_cur = glyph(state, scan_idx);

  // Display registers lag the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      an       <= 4'b1111;
      seg      <= G_BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (glyph_cur == G_BLANK) begin
        an  <= 4'b1111;
        seg <= G_BLANK;
      end else begin
        an  <= ~(4'b0001 << scan_idx);
        seg <= glyph_cur;
      end
    end
  end

endmodule
